// File: rtl/fruit_rom_rd_arbiter.sv
// Round-robin burst-read arbiter for a shared single-port template ROM.
// Issues one ROM address per cycle and tags returning data to its owner.
module fruit_rom_rd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_last,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_clk_en,
  input  logic [DATA_W-1:0]         rom_rd_data
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef struct packed {
    logic          iss;
    logic [OW-1:0] own;
    logic          last;
  } tag_t;

  state_t state, state_nx;

  logic [OW-1:0]     rr_ptr;
  logic [OW-1:0]     win;
  logic [OW-1:0]     scan_idx;
  logic              win_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  rem;
  logic              issue;
  logic              last_issue;
  logic [OW-1:0]     owner;
  logic              pipe_any;
  tag_t              tag_q [RD_LAT];

  // Pick the first valid requester after the last winner, wrapping around.
  always_comb begin
    win      = '0;
    win_ok   = 1'b0;
    scan_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = OW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        win    = scan_idx;
        win_ok = 1'b1;
      end
    end
  end

  assign sel_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign sel_len  = req_len[int'(win)*LEN_W +: LEN_W];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and the combinational grant.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          req_ready[win] = 1'b1;
          if (sel_len != LEN_W'(1)) state_nx = BURST;
        end
      end
      BURST: begin
        if (rem == LEN_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address generator: load on accept, count up while bursting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      issue      <= 1'b0;
      last_issue <= 1'b0;
      owner      <= '0;
      rem        <= '0;
      rr_ptr     <= OW'(NUM_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            rom_addr   <= sel_addr;
            issue      <= 1'b1;
            last_issue <= (sel_len == LEN_W'(1));
            owner      <= win;
            rr_ptr     <= win;
            rem        <= sel_len - LEN_W'(1);
          end else begin
            issue      <= 1'b0;
            last_issue <= 1'b0;
          end
        end
        BURST: begin
          rom_addr   <= rom_addr + ADDR_W'(1);
          issue      <= 1'b1;
          last_issue <= (rem == LEN_W'(1));
          rem        <= rem - LEN_W'(1);
        end
        default: begin
          issue      <= 1'b0;
          last_issue <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline matching the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{iss: issue, own: owner, last: last_issue};
      for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Keep the ROM clocked while any read is outstanding.
  always_comb begin
    pipe_any = 1'b0;
    for (int k = 0; k < RD_LAT; k++) pipe_any = pipe_any | tag_q[k].iss;
  end

  assign rom_clk_en = issue | pipe_any;
  assign busy       = (state == BURST) | rom_clk_en;

  // Steer the returning beat to its owner.
  always_comb begin
    rsp_valid = '0;
    if (tag_q[RD_LAT-1].iss) rsp_valid[tag_q[RD_LAT-1].own] = 1'b1;
  end

  assign rsp_last = tag_q[RD_LAT-1].last;
  assign rsp_data = rom_rd_data;

endmodule

// File: tb/tb_fruit_rom_rd_arbiter.sv
// Bench for fruit_rom_rd_arbiter: directed scenarios plus random traffic
// checked against a cycle-scheduled transaction model.
module tb_fruit_rom_rd_arbiter;

  localparam int NR = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int RL = 2;
  localparam int NC = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    rsp_valid;
  logic             rsp_last;
  logic [DW-1:0]    rsp_data;
  logic             busy;
  logic [AW-1:0]    rom_addr;
  logic             rom_clk_en;
  logic [DW-1:0]    rom_rd_data;

  fruit_rom_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .busy(busy), .rom_addr(rom_addr), .rom_clk_en(rom_clk_en),
    .rom_rd_data(rom_rd_data)
  );

  // ROM with output register, clock-enabled.
  logic [DW-1:0] rom_mem [1024];
  logic [DW-1:0] rp1, rp2;
  always @(posedge clk) if (rom_clk_en) begin
    rp1 <= rom_mem[rom_addr];
    rp2 <= rp1;
  end
  assign rom_rd_data = rp2;

  // Expected activity indexed by cycle number.
  bit          iss [NC];
  logic [AW-1:0] iad [NC];
  bit          ev  [NC];
  int          eo  [NC];
  logic [AW-1:0] ea [NC];
  bit          el  [NC];

  int cyc = 8;
  int next_free = 0;
  int mrr = NR - 1;
  int n_vec = 0;
  int n_err = 0;
  int beats = 0;
  int lasts = 0;
  int grants [$];

  bit            pv [NR];
  logic [AW-1:0] pa [NR];
  logic [LW-1:0] pl [NR];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    int w;
    bit any;
    bit ce;
    int len;
    logic [NR-1:0] er;
    logic [NR-1:0] evv;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pv[i];
      req_addr[i*AW +: AW] = pa[i];
      req_len[i*LW +: LW] = pl[i];
    end
    @(negedge clk);
    any = 1'b0;
    w = 0;
    if (cyc >= next_free)
      for (int j = NR; j >= 1; j--)
        if (pv[(mrr + j) % NR]) begin
          w = (mrr + j) % NR;
          any = 1'b1;
        end
    er = '0;
    if (any) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    ce = 1'b0;
    for (int j = 0; j <= RL; j++) if (iss[cyc - j]) ce = 1'b1;
    chk("rom_clk_en", rom_clk_en, ce);
    chk("busy", busy, ce);
    if (iss[cyc]) chk("rom_addr", rom_addr, iad[cyc]);
    evv = '0;
    if (ev[cyc]) evv[eo[cyc]] = 1'b1;
    chk("rsp_valid", rsp_valid, evv);
    if (ev[cyc]) begin
      chk("rsp_last", rsp_last, el[cyc]);
      chk("rsp_data", rsp_data, rom_mem[ea[cyc]]);
    end
    if (|rsp_valid) begin
      beats++;
      if (rsp_last) lasts++;
    end
    for (int i = 0; i < NR; i++) if (req_ready[i]) grants.push_back(i);
    if (any) begin
      len = (pl[w] == 0) ? 256 : int'(pl[w]);
      for (int k = 0; k < len; k++) begin
        iss[cyc + 1 + k] = 1'b1;
        iad[cyc + 1 + k] = AW'((int'(pa[w]) + k) % 1024);
        ev[cyc + 1 + k + RL] = 1'b1;
        eo[cyc + 1 + k + RL] = w;
        ea[cyc + 1 + k + RL] = AW'((int'(pa[w]) + k) % 1024);
        el[cyc + 1 + k + RL] = (k == len - 1);
      end
      next_free = cyc + len;
      mrr = w;
      pv[w] = 1'b0;
    end
    cyc++;
    if (cyc >= NC - 300) begin
      $display("FAIL cycle_budget got=%0d exp=<%0d", cyc, NC - 300);
      $fatal(1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clk_en", rom_clk_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_req_ready", req_ready, 0);
    for (int t = cyc - RL - 2; t < cyc + 300; t++) begin
      iss[t] = 1'b0;
      ev[t] = 1'b0;
    end
    next_free = 0;
    mrr = NR - 1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    repeat (n) step();
  endtask

  task automatic arm(input int r, input int a, input int l);
    pv[r] = 1'b1;
    pa[r] = AW'(a);
    pl[r] = LW'(l);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int g0, b0, l0, c0;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
      pl[i] = '0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    g0 = grants.size();
    repeat (12) begin
      for (int i = 0; i < NR; i++) if (!pv[i]) arm(i, $urandom_range(0, 1023), 2);
      step();
    end
    chk("rr_g0", grants[g0], 0);
    chk("rr_g1", grants[g0 + 1], 1);
    chk("rr_g2", grants[g0 + 2], 2);
    chk("rr_g3", grants[g0 + 3], 0);
    drain(10);

    b0 = beats;
    l0 = lasts;
    arm(0, 'h010, 1);
    drain_keep();
    chk("single_beats", beats - b0, 1);
    chk("single_lasts", lasts - l0, 1);

    b0 = beats;
    l0 = lasts;
    arm(1, 'h3FE, 4);
    drain_keep();
    chk("wrap_beats", beats - b0, 4);
    chk("wrap_lasts", lasts - l0, 1);

    b0 = beats;
    l0 = lasts;
    arm(2, $urandom_range(0, 1023), 0);
    step();
    drain(265);
    chk("max_beats", beats - b0, 256);
    chk("max_lasts", lasts - l0, 1);

    repeat (20) begin
      step();
      chk("idle_clk_en", rom_clk_en, 0);
      chk("idle_busy", busy, 0);
    end

    arm(0, $urandom_range(0, 1023), 16);
    c0 = cyc;
    step();
    while (cyc <= c0 + 1 + 5 + RL) step();
    do_reset();
    arm(0, $urandom_range(0, 1023), 1);
    arm(2, $urandom_range(0, 1023), 1);
    step();
    chk("post_rst_grant", grants[grants.size() - 1], 0);
    drain(8);

    repeat (1500) begin
      for (int i = 0; i < NR; i++)
        if (!pv[i] && ($urandom % 4 == 0))
          arm(i, $urandom_range(0, 1023),
              ($urandom % 60 == 0) ? 0 : $urandom_range(1, 8));
      step();
    end
    drain(270);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic drain_keep();
    step();
    drain(10);
  endtask

endmodule
